// File: rtl/fp_acc_normalize.sv
// fp_acc_normalize: converts the accumulator's {exponent, two's-complement fixed-point}
// result into IEEE FP16. It normalises one left shift per cycle, then rounds,
// range-checks (saturate to infinity / flush to zero) and packs sign/exp/mantissa.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   start      launch a conversion (sampled only while ready=1)
//   exp_in     accumulator exponent
//   acc_in     accumulator value, value = acc_in * 2^(exp_in-EXP_BIAS-MAN_W)
//   ready      idle, can accept start
//   out_valid  one-cycle pulse with each result
//   fp_out     FP16 result, held until the next result
//   overflow   result saturated to infinity
//   underflow  result flushed to zero
//
// Configuration macro: RNE_ROUND_EN selects round-to-nearest-even; when it is
// undefined the mantissa is truncated.
module fp_acc_normalize #(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned EXP_W    = 5,
  parameter int unsigned MAN_W    = 10,
  parameter int unsigned EXP_BIAS = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [ACC_W-1:0]       acc_in,
  output logic                   ready,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   fp_out,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned E_W   = EXP_W + 3;
  localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
  localparam int unsigned E_OFF = ACC_W - 1 - MAN_W;
  // Biased exponent of infinity (all ones).
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(2 * EXP_BIAS + 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_PACK
  } state_e;

  state_e                   state_q, state_d;
  logic [ACC_W-1:0]         mag_q, mag_d;
  logic signed [E_W-1:0]    e_q, e_d;
  logic                     sign_q, sign_d;
  logic                     zero_q, zero_d;
  logic                     ready_q, ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [FP_W-1:0]          fp_q, fp_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  logic [ACC_W-1:0]         mag_abs;
  logic [MAN_W-1:0]         man_r;
  logic signed [E_W-1:0]    e_r;
  logic                     is_inf;
  logic                     is_tiny;

  // Magnitude; the most-negative input maps onto itself, which is the correct unsigned value.
  assign mag_abs = acc_in[ACC_W-1] ? (~acc_in + ACC_W'(1)) : acc_in;

  // Rounded mantissa/exponent of the normalised magnitude (implicit leading one at the MSB).
`ifdef RNE_ROUND_EN
  localparam int unsigned G_IDX = ACC_W - 2 - MAN_W;
  logic             guard_bit;
  logic             sticky_bit;
  logic             round_up;
  logic [MAN_W:0]   man_sum;

  assign guard_bit  = mag_q[G_IDX];
  assign sticky_bit = |mag_q[G_IDX-1:0];
  assign round_up   = guard_bit & (sticky_bit | mag_q[G_IDX+1]);
  assign man_sum    = {1'b0, mag_q[ACC_W-2 -: MAN_W]} + (MAN_W+1)'(round_up);
  assign man_r      = man_sum[MAN_W-1:0];
  assign e_r        = e_q + E_W'(man_sum[MAN_W]);
`else
  assign man_r      = mag_q[ACC_W-2 -: MAN_W];
  assign e_r        = e_q;
`endif

  assign is_inf  = (e_r >= E_MAX);
  assign is_tiny = (e_r <= E_ZERO);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      fp_q        <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      fp_q        <= fp_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Next-state and output logic. The exit to PACK looks at the value being
  // loaded into mag, so an already-normalised magnitude skips NORM entirely and
  // each result takes exactly leading-zeros + 2 edges.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    e_d         = e_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    ready_d     = ready_q;
    out_valid_d = 1'b0;
    fp_d        = fp_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;

    case (state_q)
      S_IDLE: begin
        if (start && ready_q) begin
          sign_d  = acc_in[ACC_W-1];
          mag_d   = mag_abs;
          e_d     = E_W'(exp_in) + E_W'(E_OFF);
          zero_d  = (acc_in == '0);
          ready_d = 1'b0;
          state_d = ((acc_in == '0) || mag_abs[ACC_W-1]) ? S_PACK : S_NORM;
        end
      end
      S_NORM: begin
        mag_d = mag_q << 1;
        e_d   = e_q - E_W'(1);
        if (mag_q[ACC_W-2]) begin
          state_d = S_PACK;
        end
      end
      S_PACK: begin
        out_valid_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        if (zero_q) begin
          fp_d = '0;
        end else if (is_inf) begin
          fp_d  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (is_tiny) begin
          fp_d  = {sign_q, {(FP_W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          fp_d = {sign_q, e_r[EXP_W-1:0], man_r};
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign ready     = ready_q;
  assign out_valid = out_valid_q;
  assign fp_out    = fp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
